// File: rtl/s_rca16_rr_sched.sv
// Round-robin scheduler sharing one signed ripple-carry adder among N_REQ requesters.
// The 17-bit sum and the winning index sit in a single-entry output register with valid/ready.
module s_rca16_rr_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH:0]         res_sum,
  output logic [ID_W-1:0]        res_id
);

  localparam logic [ID_W:0]   N_REQ_L  = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  logic            res_valid_q, res_valid_d;
  logic [WIDTH:0]  res_sum_q, res_sum_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand;
  logic            free;
  logic            fire;

  // Rotating priority scan: candidate index is ptr+k folded back into 0..N_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= N_REQ_L) cand = cand - N_REQ_L;
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign free      = !res_valid_q || res_ready;
  assign fire      = free && grant_found && !rst;
  assign req_ready = fire ? (N_REQ'(1) << grant_idx) : '0;

  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   a_ext, b_ext, sum_rca, carry;

  assign a_sel    = req_a[grant_idx*WIDTH +: WIDTH];
  assign b_sel    = req_b[grant_idx*WIDTH +: WIDTH];
  assign a_ext    = {a_sel[WIDTH-1], a_sel};
  assign b_ext    = {b_sel[WIDTH-1], b_sel};
  assign carry[0] = 1'b0;

  // Full-adder chain over the sign-extended operands; the final carry-out is dropped.
  for (genvar gi = 0; gi <= WIDTH; gi++) begin : gen_fa
    assign sum_rca[gi] = a_ext[gi] ^ b_ext[gi] ^ carry[gi];
    if (gi < WIDTH) begin : gen_carry
      assign carry[gi+1] = (a_ext[gi] & b_ext[gi]) | (carry[gi] & (a_ext[gi] ^ b_ext[gi]));
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    ptr_d       = ptr_q;
    if (fire) begin
      res_valid_d = 1'b1;
      res_sum_d   = sum_rca;
      res_id_d    = grant_idx;
      ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_s_rca16_rr_sched.sv
// Directed bench for s_rca16_rr_sched: grants, signed sums, rotation, backpressure and reset.
module tb_s_rca16_rr_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [16:0] res_sum;
  logic [1:0]  res_id;

  int compared;
  int mismatched;

  s_rca16_rr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int port, input logic [15:0] a, input logic [15:0] b);
    req_a[port*16 +: 16] = a;
    req_b[port*16 +: 16] = b;
  endtask

  task automatic chk_res(input string tag, input logic [1:0] id, input logic [16:0] sum);
    chk({tag, "_valid"}, 32'(res_valid), 32'h1);
    chk({tag, "_id"},    32'(res_id),    32'(id));
    chk({tag, "_sum"},   32'(res_sum),   32'(sum));
    $display("txn %s: id=%0d sum=%05h", tag, res_id, res_sum);
  endtask

  logic [16:0] fair_sum [4];
  logic [1:0]  held_id;
  logic [16:0] held_sum;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    res_ready  = 1'b0;

    // Reset: no grants while rst is high, cleared outputs afterwards.
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    cyc();
    cyc();
    chk("rst_ready2", 32'(req_ready), 32'h0);
    req_valid = 4'b0000;
    rst       = 1'b0;
    #1;
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_sum",   32'(res_sum),   32'h0);
    chk("rst_id",    32'(res_id),    32'h0);

    // Single request on port 1: 0x7FFF + 1 = +32768.
    set_ops(1, 16'h7FFF, 16'h0001);
    req_valid = 4'b0010;
    res_ready = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'h2);
    cyc();
    chk_res("single", 2'd1, 17'h08000);

    // ptr must now be 2: with all valid, port 2 wins.
    set_ops(2, 16'h0003, 16'hFFFE);
    set_ops(0, 16'h0005, 16'h0005);
    set_ops(3, 16'h0010, 16'h0020);
    req_valid = 4'b1111;
    #1;
    chk("ptr2_ready", 32'(req_ready), 32'h4);
    cyc();
    chk_res("ptr2", 2'd2, 17'h00001);

    req_valid = 4'b0000;
    cyc();
    chk("drain_valid", 32'(res_valid), 32'h0);

    // Negative extremes on port 0 with ptr=3 (scan wraps to 0).
    set_ops(0, 16'h8000, 16'h8000);
    req_valid = 4'b0001;
    #1;
    chk("negmax_ready", 32'(req_ready), 32'h1);
    cyc();
    chk_res("negmax", 2'd0, 17'h10000);
    set_ops(0, 16'hFFFF, 16'h0001);
    #1;
    chk("neg1_ready", 32'(req_ready), 32'h1);
    cyc();
    chk_res("neg1", 2'd0, 17'h00000);
    set_ops(0, 16'h7FFF, 16'h7FFF);
    cyc();
    chk_res("posmax", 2'd0, 17'h0FFFE);

    // Grant port 3 so ptr wraps to 0 before the fairness run.
    req_valid = 4'b1000;
    cyc();
    chk_res("wrap3", 2'd3, 17'h00030);

    // Fairness: all valid, res_ready=1, grants rotate 0..3 twice.
    set_ops(0, 16'h0001, 16'h0002);
    set_ops(1, 16'h1000, 16'h1000);
    set_ops(2, 16'hFFFF, 16'hFFFF);
    set_ops(3, 16'h8000, 16'h7FFF);
    fair_sum[0] = 17'h00003;
    fair_sum[1] = 17'h02000;
    fair_sum[2] = 17'h1FFFE;
    fair_sum[3] = 17'h1FFFF;
    req_valid   = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      cyc();
      chk_res("fair", 2'(k % 4), fair_sum[k % 4]);
    end

    // Backpressure: grant port 2, then hold res_ready low for 3 cycles.
    req_valid = 4'b0100;
    cyc();
    chk_res("bp_grant", 2'd2, 17'h1FFFE);
    held_id   = 2'd2;
    held_sum  = 17'h1FFFE;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      cyc();
      chk_res("bp_hold", held_id, held_sum);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    cyc();
    chk_res("bp_release", 2'd3, 17'h1FFFF);

    // Wrap and skip: set ptr=3 via port 2, then only port 1 valid.
    req_valid = 4'b0100;
    cyc();
    chk_res("skip_pre", 2'd2, 17'h1FFFE);
    req_valid = 4'b0010;
    #1;
    chk("skip_ready", 32'(req_ready), 32'h2);
    cyc();
    chk_res("skip", 2'd1, 17'h02000);
    req_valid = 4'b0110;
    #1;
    chk("skip_ptr2_ready", 32'(req_ready), 32'h4);
    cyc();
    chk_res("skip_ptr2", 2'd2, 17'h1FFFE);

    // Reset while FULL under backpressure (ptr is 3 here).
    res_ready = 1'b0;
    req_valid = 4'b1111;
    cyc();
    chk_res("pre_rst", 2'd2, 17'h1FFFE);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("mid_rst_valid", 32'(res_valid), 32'h0);
    chk("mid_rst_sum",   32'(res_sum),   32'h0);
    chk("mid_rst_id",    32'(res_id),    32'h0);
    rst       = 1'b0;
    req_valid = 4'b1010;
    res_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    cyc();
    chk_res("post_rst", 2'd1, 17'h02000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
